// File: rtl/bp_nonsynth_pkg.sv
// Shared types for the non-synthesizable co-simulation monitors.
// The watchdog state and cause encodings are visible on its output ports.
package bp_nonsynth_pkg;

    typedef enum logic [1:0] {
        e_wd_idle = 2'b00,
        e_wd_run  = 2'b01,
        e_wd_done = 2'b10
    } bp_nonsynth_watchdog_state_e;

    typedef enum logic [1:0] {
        e_wd_none  = 2'b00,
        e_wd_cap   = 2'b01,
        e_wd_stall = 2'b10,
        e_wd_loop  = 2'b11
    } bp_nonsynth_watchdog_cause_e;

endpackage

// File: rtl/bp_nonsynth_watchdog_counter.sv
// Saturating up-counter with synchronous clear and async active-low reset.
// Clear takes priority over counting; reaching max_val_p holds silently.
module bp_nonsynth_watchdog_counter #(
    parameter int                 width_p   = 32,
    parameter logic [width_p-1:0] max_val_p = '1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               up_i,
    output logic [width_p-1:0] count_o
);

    logic [width_p-1:0] r_count;
    logic [width_p-1:0] w_count_next;

    always_comb begin
        w_count_next = r_count;
        if (clear_i) begin
            w_count_next = '0;
        end else if (up_i && (r_count != max_val_p)) begin
            w_count_next = r_count + width_p'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign count_o = r_count;

endmodule

// File: rtl/bp_nonsynth_commit_watchdog.sv
// Commit-stream watchdog: counts retirements and latches the first end-of-run
// cause (instruction cap, stall, or tight self-loop) until reset.
module bp_nonsynth_commit_watchdog
    import bp_nonsynth_pkg::*;
#(
    parameter int vaddr_width_p  = 39,
    parameter int cnt_width_p    = 32,
    parameter int stall_cycles_p = 100000,
    parameter int loop_count_p   = 1024
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     freeze_i,
    input  logic                     en_i,
    input  logic                     commit_v_i,
    input  logic [vaddr_width_p-1:0] commit_pc_i,
    input  logic                     trap_v_i,
    input  logic [31:0]              instr_cap_i,
    output logic [cnt_width_p-1:0]   instr_cnt_o,
    output logic                     finish_o,
    output logic [1:0]               cause_o,
    output logic [1:0]               state_o
);

    // One extra bit so a saturated count plus one cannot alias a small cap.
    localparam int cmp_width_lp = ((cnt_width_p > 32) ? cnt_width_p : 32) + 1;

    localparam logic [cnt_width_p-1:0] instr_max_lp  = '1;
    localparam logic [cnt_width_p-1:0] stall_max_lp  = cnt_width_p'(stall_cycles_p);
    localparam logic [cnt_width_p-1:0] stall_trig_lp = cnt_width_p'(stall_cycles_p - 1);
    localparam logic [cnt_width_p-1:0] loop_max_lp   = cnt_width_p'(loop_count_p);
    localparam logic [cnt_width_p-1:0] loop_trig_lp  = cnt_width_p'(loop_count_p - 2);

    bp_nonsynth_watchdog_state_e r_state, w_state_next;
    bp_nonsynth_watchdog_cause_e r_cause, w_cause_next;
    logic                        r_finish, w_finish_next;
    logic [vaddr_width_p-1:0]    r_last_pc;

    logic [cnt_width_p-1:0]  w_instr_cnt;
    logic [cnt_width_p-1:0]  w_stall_cnt;
    logic [cnt_width_p-1:0]  w_loop_cnt;
    logic [cmp_width_lp-1:0] w_cnt_plus1;
    logic [cmp_width_lp-1:0] w_cap_ext;

    logic w_valid;
    logic w_run;
    logic w_leave;
    logic w_active;
    logic w_pc_match;
    logic w_cap_hit;
    logic w_loop_hit;
    logic w_stall_hit;

    // PC 0 marks a pipeline bubble, never a real retirement.
    assign w_valid    = commit_v_i && (commit_pc_i != '0);
    assign w_run      = (r_state == e_wd_run);
    assign w_leave    = w_run && (!en_i || freeze_i);
    assign w_active   = w_run && !w_leave;
    assign w_pc_match = w_valid && (commit_pc_i == r_last_pc);

    assign w_cnt_plus1 = cmp_width_lp'(w_instr_cnt) + cmp_width_lp'(1);
    assign w_cap_ext   = cmp_width_lp'(instr_cap_i);

    assign w_cap_hit   = w_active && w_valid && (instr_cap_i != 32'd0)
                      && (w_cnt_plus1 == w_cap_ext);
    assign w_loop_hit  = w_active && w_pc_match && (w_loop_cnt == loop_trig_lp);
    assign w_stall_hit = w_active && !w_valid && !trap_v_i
                      && (w_stall_cnt == stall_trig_lp);

    bp_nonsynth_watchdog_counter #(
        .width_p   (cnt_width_p),
        .max_val_p (instr_max_lp)
    ) u_instr_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (w_leave),
        .up_i    (w_active && w_valid),
        .count_o (w_instr_cnt)
    );

    bp_nonsynth_watchdog_counter #(
        .width_p   (cnt_width_p),
        .max_val_p (stall_max_lp)
    ) u_stall_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (w_leave || (w_active && (w_valid || trap_v_i))),
        .up_i    (w_active),
        .count_o (w_stall_cnt)
    );

    // A trap in the same cycle as a matching commit still leaves loop_cnt at 0.
    bp_nonsynth_watchdog_counter #(
        .width_p   (cnt_width_p),
        .max_val_p (loop_max_lp)
    ) u_loop_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (w_leave || (w_active && (trap_v_i || (w_valid && !w_pc_match)))),
        .up_i    (w_active && w_pc_match),
        .count_o (w_loop_cnt)
    );

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_last_pc <= '0;
        end else if (w_leave) begin
            r_last_pc <= '0;
        end else if (w_active && w_valid && !w_pc_match) begin
            r_last_pc <= commit_pc_i;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_cause_next  = r_cause;
        w_finish_next = r_finish;
        unique case (r_state)
            e_wd_idle: begin
                if (en_i && !freeze_i) begin
                    w_state_next = e_wd_run;
                end
            end
            e_wd_run: begin
                if (w_leave) begin
                    w_state_next = e_wd_idle;
                end else if (w_cap_hit || w_loop_hit || w_stall_hit) begin
                    w_state_next  = e_wd_done;
                    w_finish_next = 1'b1;
                    if (w_cap_hit) begin
                        w_cause_next = e_wd_cap;
                    end else if (w_loop_hit) begin
                        w_cause_next = e_wd_loop;
                    end else begin
                        w_cause_next = e_wd_stall;
                    end
                end
            end
            e_wd_done: begin
                w_state_next = e_wd_done;
            end
            default: begin
                w_state_next = e_wd_idle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state  <= e_wd_idle;
            r_cause  <= e_wd_none;
            r_finish <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cause  <= w_cause_next;
            r_finish <= w_finish_next;
        end
    end

    assign instr_cnt_o = w_instr_cnt;
    assign finish_o    = r_finish;
    assign cause_o     = r_cause;
    assign state_o     = r_state;

endmodule

// File: tb/tb_bp_nonsynth_commit_watchdog.sv
// Directed bench for the commit watchdog: each step pushes its expected outputs
// into a scoreboard queue, which is popped and compared after the clock edge.
module tb_bp_nonsynth_commit_watchdog;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;
    localparam logic [1:0] C_NONE  = 2'b00;
    localparam logic [1:0] C_CAP   = 2'b01;
    localparam logic [1:0] C_STALL = 2'b10;
    localparam logic [1:0] C_LOOP  = 2'b11;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        freeze = 1'b0;
    logic        en = 1'b0;
    logic        commit_v = 1'b0;
    logic [38:0] commit_pc = '0;
    logic        trap_v = 1'b0;
    logic [31:0] instr_cap = '0;
    logic [31:0] instr_cnt;
    logic        finish;
    logic [1:0]  cause;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    logic [36:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    bp_nonsynth_commit_watchdog #(
        .vaddr_width_p  (39),
        .cnt_width_p    (32),
        .stall_cycles_p (16),
        .loop_count_p   (4)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset_n),
        .freeze_i    (freeze),
        .en_i        (en),
        .commit_v_i  (commit_v),
        .commit_pc_i (commit_pc),
        .trap_v_i    (trap_v),
        .instr_cap_i (instr_cap),
        .instr_cnt_o (instr_cnt),
        .finish_o    (finish),
        .cause_o     (cause),
        .state_o     (state)
    );

    // One clock of stimulus; expected outputs are those seen just after the edge.
    task automatic step(input logic v, input logic [38:0] pc, input logic t,
                        input logic [31:0] ecnt, input logic efin,
                        input logic [1:0] ecause, input logic [1:0] estate,
                        input string tag);
        logic [36:0] obs;
        logic [36:0] expv;
        string       tg;
        commit_v  = v;
        commit_pc = pc;
        trap_v    = t;
        exp_q.push_back({ecnt, efin, ecause, estate});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        expv = exp_q.pop_front();
        tg   = tag_q.pop_front();
        obs  = {instr_cnt, finish, cause, state};
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed cnt=%0d fin=%b cause=%b state=%b expected cnt=%0d fin=%b cause=%b state=%b",
                   tg, obs[36:5], obs[4], obs[3:2], obs[1:0],
                   expv[36:5], expv[4], expv[3:2], expv[1:0]);
        end
        $display("%s: cnt=%0d fin=%b cause=%b state=%b", tg, instr_cnt, finish, cause, state);
        commit_v  = 1'b0;
        commit_pc = '0;
        trap_v    = 1'b0;
    endtask

    // Asserts reset between clock edges and checks the outputs clear at once.
    task automatic do_reset(input string tag);
        logic [36:0] obs;
        en      = 1'b0;
        freeze  = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        obs = {instr_cnt, finish, cause, state};
        checks++;
        assert (obs === 37'd0) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, 37'd0);
        end
        $display("%s: cnt=%0d fin=%b cause=%b state=%b", tag, instr_cnt, finish, cause, state);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Cap: five distinct commits with cap 5, then extra commits do not count.
        do_reset("reset_init");
        instr_cap = 32'd5;
        en = 1'b1;
        step(1'b0, 39'd0, 1'b0, 0, 1'b0, C_NONE, ST_RUN, "cap_enter");
        for (int n = 0; n < 5; n++) begin
            step(1'b1, 39'h80000000 + 39'(4 * n), 1'b0, 32'(n + 1),
                 (n == 4), (n == 4) ? C_CAP : C_NONE, (n == 4) ? ST_DONE : ST_RUN,
                 $sformatf("cap_commit%0d", n + 1));
        end
        for (int n = 0; n < 2; n++) begin
            step(1'b1, 39'h80000100 + 39'(4 * n), 1'b0, 5, 1'b1, C_CAP, ST_DONE, "cap_hold");
        end
        en = 1'b0;
        step(1'b0, 39'd0, 1'b0, 5, 1'b1, C_CAP, ST_DONE, "cap_done_ignores_en");

        // Stall: one commit then 16 idle cycles.
        do_reset("reset_stall");
        instr_cap = 32'd0;
        en = 1'b1;
        step(1'b0, 39'd0, 1'b0, 0, 1'b0, C_NONE, ST_RUN, "stall_enter");
        step(1'b1, 39'h80000000, 1'b0, 1, 1'b0, C_NONE, ST_RUN, "stall_commit");
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 39'd0, 1'b0, 1, (i == 16), (i == 16) ? C_STALL : C_NONE,
                 (i == 16) ? ST_DONE : ST_RUN, $sformatf("stall_idle%0d", i));
        end

        // Stall variant: a trap on idle cycle 10 pushes the trigger to cycle 26.
        do_reset("reset_stall_trap");
        en = 1'b1;
        step(1'b0, 39'd0, 1'b0, 0, 1'b0, C_NONE, ST_RUN, "stall_trap_enter");
        step(1'b1, 39'h80000000, 1'b0, 1, 1'b0, C_NONE, ST_RUN, "stall_trap_commit");
        for (int i = 1; i <= 26; i++) begin
            step(1'b0, 39'd0, (i == 10), 1, (i == 26), (i == 26) ? C_STALL : C_NONE,
                 (i == 26) ? ST_DONE : ST_RUN, $sformatf("stall_trap_idle%0d", i));
        end

        // Loop: four identical retirements.
        do_reset("reset_loop");
        en = 1'b1;
        step(1'b0, 39'd0, 1'b0, 0, 1'b0, C_NONE, ST_RUN, "loop_enter");
        for (int k = 1; k <= 4; k++) begin
            step(1'b1, 39'h80000100, 1'b0, 32'(k), (k == 4), (k == 4) ? C_LOOP : C_NONE,
                 (k == 4) ? ST_DONE : ST_RUN, $sformatf("loop_commit%0d", k));
        end

        // Async reset in done clears everything without a clock edge.
        do_reset("reset_in_done");

        // Loop broken by a trap between the 2nd and 3rd commits.
        en = 1'b1;
        step(1'b0, 39'd0, 1'b0, 0, 1'b0, C_NONE, ST_RUN, "looptrap_enter");
        step(1'b1, 39'h80000100, 1'b0, 1, 1'b0, C_NONE, ST_RUN, "looptrap_c1");
        step(1'b1, 39'h80000100, 1'b0, 2, 1'b0, C_NONE, ST_RUN, "looptrap_c2");
        step(1'b0, 39'd0, 1'b1, 2, 1'b0, C_NONE, ST_RUN, "looptrap_trap");
        step(1'b1, 39'h80000100, 1'b0, 3, 1'b0, C_NONE, ST_RUN, "looptrap_c3");
        step(1'b1, 39'h80000100, 1'b0, 4, 1'b0, C_NONE, ST_RUN, "looptrap_c4");
        step(1'b1, 39'h80000100, 1'b0, 5, 1'b1, C_LOOP, ST_DONE, "looptrap_c5");

        // Priority: the 4th identical commit also reaches cap 4.
        do_reset("reset_prio");
        instr_cap = 32'd4;
        en = 1'b1;
        step(1'b0, 39'd0, 1'b0, 0, 1'b0, C_NONE, ST_RUN, "prio_enter");
        for (int k = 1; k <= 4; k++) begin
            step(1'b1, 39'h80000100, 1'b0, 32'(k), (k == 4), (k == 4) ? C_CAP : C_NONE,
                 (k == 4) ? ST_DONE : ST_RUN, $sformatf("prio_commit%0d", k));
        end

        // Freeze mid-run clears counters; re-entry counts from zero.
        do_reset("reset_freeze");
        instr_cap = 32'd0;
        en = 1'b1;
        step(1'b0, 39'd0, 1'b0, 0, 1'b0, C_NONE, ST_RUN, "frz_enter");
        for (int k = 1; k <= 3; k++) begin
            step(1'b1, 39'h80000200 + 39'(8 * k), 1'b0, 32'(k), 1'b0, C_NONE, ST_RUN,
                 $sformatf("frz_commit%0d", k));
        end
        freeze = 1'b1;
        step(1'b0, 39'd0, 1'b0, 0, 1'b0, C_NONE, ST_IDLE, "frz_frozen");
        step(1'b1, 39'h80000300, 1'b0, 0, 1'b0, C_NONE, ST_IDLE, "frz_idle_commit");
        freeze = 1'b0;
        step(1'b0, 39'd0, 1'b0, 0, 1'b0, C_NONE, ST_RUN, "frz_reenter");
        step(1'b1, 39'h80000300, 1'b0, 1, 1'b0, C_NONE, ST_RUN, "frz_resume");

        // PC-zero bubbles never count and do not hold off the stall.
        do_reset("reset_bubble");
        en = 1'b1;
        step(1'b0, 39'd0, 1'b0, 0, 1'b0, C_NONE, ST_RUN, "bubble_enter");
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 39'd0, 1'b0, 0, (i >= 16), (i >= 16) ? C_STALL : C_NONE,
                 (i >= 16) ? ST_DONE : ST_RUN, $sformatf("bubble%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
